// File: rtl/frame_buffer_dbl_pkg.sv
// Shared types and address helpers for the double-buffered frame store.
package frame_buffer_dbl_pkg;

  typedef enum logic {S_IDLE, S_CLEAR} fb_state_t;

  localparam int DEF_PIXEL_W     = 3;
  localparam int DEF_CLEAR_COLOR = 0;

  // Inputs are widened to 32 bits so an H/V that is an exact power of two compares correctly.
  function automatic logic fb_in_range(input int unsigned x, input int unsigned y,
                                       input int unsigned h, input int unsigned v);
    return (x < h) && (y < v);
  endfunction

  function automatic int unsigned fb_addr(input int unsigned x, input int unsigned y,
                                          input int unsigned h);
    return y * h + x;
  endfunction

endpackage

// File: rtl/frame_buffer_dbl_bank.sv
// One frame bank: simple dual-port RAM, synchronous write, registered read.
module fb_bank #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5,
  parameter int DATA_W = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/frame_buffer_dbl.sv
// Double-buffered frame store: writer fills the back bank, scan-out reads the front,
// banks swap on vsync and the new back bank is swept to CLEAR_COLOR.
module frame_buffer_dbl
  import frame_buffer_dbl_pkg::*;
#(
  parameter int H_ACTIVE      = 640,
  parameter int V_ACTIVE      = 480,
  parameter int PIXEL_W       = DEF_PIXEL_W,
  parameter int CLEAR_COLOR   = DEF_CLEAR_COLOR,
  parameter int CLEAR_ON_SWAP = 1,
  localparam int X_W    = $clog2(H_ACTIVE),
  localparam int Y_W    = $clog2(V_ACTIVE),
  localparam int DEPTH  = H_ACTIVE * V_ACTIVE,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               vsync,
  input  logic               wr_en,
  input  logic [X_W-1:0]     wr_x,
  input  logic [Y_W-1:0]     wr_y,
  input  logic [PIXEL_W-1:0] wr_data,
  output logic               wr_ready,
  input  logic [X_W-1:0]     rd_x,
  input  logic [Y_W-1:0]     rd_y,
  output logic [PIXEL_W-1:0] rd_data,
  output logic               front_sel,
  output logic               busy,
  output logic [15:0]        frame_cnt,
  output logic [15:0]        drop_cnt
);

  localparam logic [PIXEL_W-1:0] CLR_PIX   = PIXEL_W'(CLEAR_COLOR);
  localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(DEPTH - 1);

  fb_state_t                  state;
  logic [ADDR_W-1:0]          clr_addr, wr_addr, rd_addr, bank_waddr;
  logic                       vs_q, vs_edge, swap_pending, front_valid;
  logic                       clearing, wr_ok, rd_ok, rd_ok_q, rd_sel_q, bank_wr;
  logic [PIXEL_W-1:0]         bank_wdata;
  logic [1:0][PIXEL_W-1:0]    bank_q;

  assign vs_edge  = vsync & ~vs_q;
  assign clearing = (state == S_CLEAR);
  assign wr_ok    = fb_in_range(32'(wr_x), 32'(wr_y), H_ACTIVE, V_ACTIVE);
  assign rd_ok    = fb_in_range(32'(rd_x), 32'(rd_y), H_ACTIVE, V_ACTIVE);
  assign wr_addr  = ADDR_W'(fb_addr(32'(wr_x), 32'(wr_y), H_ACTIVE));
  assign rd_addr  = rd_ok ? ADDR_W'(fb_addr(32'(rd_x), 32'(rd_y), H_ACTIVE)) : '0;

  // The clear engine and the writer both target the back bank; wr_ready keeps them exclusive.
  assign bank_waddr = clearing ? clr_addr : wr_addr;
  assign bank_wdata = clearing ? CLR_PIX : wr_data;
  assign bank_wr    = clearing | (wr_en & wr_ready & wr_ok);

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fb_bank #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(PIXEL_W)) u_bank (
      .clk   (clk),
      .we    (bank_wr & (front_sel != 1'(b))),
      .waddr (bank_waddr),
      .wdata (bank_wdata),
      .raddr (rd_addr),
      .rdata (bank_q[b])
    );
  end

  // Bank select is captured with the RAM read so a read issued in the swap cycle sees the old front.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ok_q  <= 1'b0;
      rd_sel_q <= 1'b0;
    end else begin
      rd_ok_q  <= front_valid & rd_ok;
      rd_sel_q <= front_sel;
    end
  end

  assign rd_data = rd_ok_q ? bank_q[rd_sel_q] : CLR_PIX;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_CLEAR;
      clr_addr     <= '0;
      busy         <= 1'b1;
      wr_ready     <= 1'b0;
      front_sel    <= 1'b0;
      front_valid  <= 1'b0;
      frame_cnt    <= '0;
      drop_cnt     <= '0;
      swap_pending <= 1'b0;
      vs_q         <= 1'b0;
    end else begin
      vs_q <= vsync;
      case (state)
        S_IDLE: begin
          if (vs_edge) begin
            front_sel   <= ~front_sel;
            front_valid <= 1'b1;
            frame_cnt   <= frame_cnt + 16'd1;
            if (CLEAR_ON_SWAP != 0) begin
              state    <= S_CLEAR;
              clr_addr <= '0;
              busy     <= 1'b1;
              wr_ready <= 1'b0;
            end
          end
        end
        S_CLEAR: begin
          if (vs_edge && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
          if (clr_addr == LAST_ADDR) begin
            clr_addr <= '0;
            if (swap_pending || vs_edge) begin
              // Deferred swap fires straight out of the clear, no idle cycle in between.
              swap_pending <= 1'b0;
              front_sel    <= ~front_sel;
              front_valid  <= 1'b1;
              frame_cnt    <= frame_cnt + 16'd1;
              if (CLEAR_ON_SWAP == 0) begin
                state    <= S_IDLE;
                busy     <= 1'b0;
                wr_ready <= 1'b1;
              end
            end else begin
              state    <= S_IDLE;
              busy     <= 1'b0;
              wr_ready <= 1'b1;
            end
          end else begin
            clr_addr <= clr_addr + 1'b1;
            if (vs_edge) swap_pending <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_buffer_dbl.sv
// Two instances share one stimulus stream: 8x4 with clear-on-swap, 6x3 without clear.
module tb_frame_buffer_dbl;

  localparam int NH  [2] = '{8, 6};
  localparam int NV  [2] = '{4, 3};
  localparam int CLR [2] = '{1, 0};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vsync = 1'b0;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_x = '0, rd_x = '0;
  logic [1:0]  wr_y = '0, rd_y = '0;
  logic [2:0]  wr_data = '0;
  logic [1:0]  o_busy, o_wr_ready, o_front;
  logic [15:0] o_frame [2];
  logic [15:0] o_drop  [2];
  logic [2:0]  o_rd    [2];

  int errs = 0, checks = 0;

  always #5 clk = ~clk;

  frame_buffer_dbl #(.H_ACTIVE(8), .V_ACTIVE(4), .PIXEL_W(3), .CLEAR_COLOR(0), .CLEAR_ON_SWAP(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .vsync(vsync), .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y),
    .wr_data(wr_data), .wr_ready(o_wr_ready[0]), .rd_x(rd_x), .rd_y(rd_y), .rd_data(o_rd[0]),
    .front_sel(o_front[0]), .busy(o_busy[0]), .frame_cnt(o_frame[0]), .drop_cnt(o_drop[0]));

  frame_buffer_dbl #(.H_ACTIVE(6), .V_ACTIVE(3), .PIXEL_W(3), .CLEAR_COLOR(0), .CLEAR_ON_SWAP(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .vsync(vsync), .wr_en(wr_en), .wr_x(wr_x), .wr_y(wr_y),
    .wr_data(wr_data), .wr_ready(o_wr_ready[1]), .rd_x(rd_x), .rd_y(rd_y), .rd_data(o_rd[1]),
    .front_sel(o_front[1]), .busy(o_busy[1]), .frame_cnt(o_frame[1]), .drop_cnt(o_drop[1]));

  // Reference model: bank contents as plain arrays, a clear is applied to the whole back bank
  // when it starts, and m_clr counts the cycles the clear still occupies.
  int m_front[2], m_valid[2], m_frame[2], m_drop[2], m_clr[2], m_pend[2], m_vsq[2], m_rd[2];
  bit m_rdk[2];
  int mem   [2][2][32];
  bit known [2][2][32];

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit inr(input int d, input int x, input int y);
    return x < NH[d] && y < NV[d];
  endfunction

  task automatic start_clear(input int d);
    for (int a = 0; a < NH[d] * NV[d]; a++) begin
      mem[d][1 - m_front[d]][a]   = 0;
      known[d][1 - m_front[d]][a] = 1'b1;
    end
    m_clr[d] = NH[d] * NV[d];
  endtask

  task automatic do_swap(input int d);
    m_front[d] = 1 - m_front[d];
    m_valid[d] = 1;
    m_frame[d] = (m_frame[d] + 1) % 65536;
    if (CLR[d] != 0) start_clear(d);
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_front[d] = 0; m_valid[d] = 0; m_frame[d] = 0; m_drop[d] = 0;
      m_pend[d] = 0; m_vsq[d] = 0; m_rd[d] = 0; m_rdk[d] = 1'b1;
      start_clear(d);
    end
  endtask

  task automatic model_step();
    bit e;
    for (int d = 0; d < 2; d++) begin
      e = (vsync == 1'b1) && (m_vsq[d] == 0);
      m_vsq[d] = int'(vsync);
      if (m_valid[d] != 0 && inr(d, int'(rd_x), int'(rd_y))) begin
        m_rd[d]  = mem[d][m_front[d]][int'(rd_y) * NH[d] + int'(rd_x)];
        m_rdk[d] = known[d][m_front[d]][int'(rd_y) * NH[d] + int'(rd_x)];
      end else begin
        m_rd[d] = 0; m_rdk[d] = 1'b1;
      end
      if (m_clr[d] == 0) begin
        if (wr_en && inr(d, int'(wr_x), int'(wr_y))) begin
          mem[d][1 - m_front[d]][int'(wr_y) * NH[d] + int'(wr_x)]   = int'(wr_data);
          known[d][1 - m_front[d]][int'(wr_y) * NH[d] + int'(wr_x)] = 1'b1;
        end
        if (e) do_swap(d);
      end else begin
        if (e) begin
          if (m_drop[d] < 65535) m_drop[d]++;
          m_pend[d] = 1;
        end
        m_clr[d]--;
        if (m_clr[d] == 0 && m_pend[d] != 0) begin
          m_pend[d] = 0;
          do_swap(d);
        end
      end
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("busy%0d", d), o_busy[d], m_clr[d] > 0);
      chk($sformatf("wr_ready%0d", d), o_wr_ready[d], m_clr[d] == 0);
      chk($sformatf("front_sel%0d", d), o_front[d], m_front[d]);
      chk($sformatf("frame_cnt%0d", d), o_frame[d], m_frame[d]);
      chk($sformatf("drop_cnt%0d", d), o_drop[d], m_drop[d]);
      if (m_rdk[d]) chk($sformatf("rd_data%0d", d), o_rd[d], m_rd[d]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic wait_idle_a(input string tag);
    int n = 0;
    while (o_busy[0] && n < 200) begin step(); n++; end
    chk(tag, o_busy[0], 0);
  endtask

  task automatic busy_len_a(input string tag);
    int n = 0;
    while (o_busy[0] && n < 100) begin step(); n++; end
    chk(tag, n, 32);
  endtask

  initial begin
    int n;
    @(negedge clk);
    model_reset();
    #1 check_all();
    repeat (2) step();
    rst_n = 1'b1;
    busy_len_a("rst_clear_len");

    // first frame: pixel lands in back bank, visible after the swap
    wr_en = 1'b1; wr_x = 3'd3; wr_y = 2'd2; wr_data = 3'd5;
    step();
    wr_en = 1'b0; vsync = 1'b1;
    step();
    chk("swap1_front", o_front[0], 1);
    chk("swap1_frame", o_frame[0], 1);
    rd_x = 3'd3; rd_y = 2'd2;
    step();
    chk("swap1_read", o_rd[0], 5);
    vsync = 1'b0;

    // edge mid-clear is deferred and fires when the clear completes
    repeat (8) step();
    vsync = 1'b1; step(); vsync = 1'b0;
    chk("defer_drop", o_drop[0], 1);
    n = 0;
    while (o_front[0] != 1'b0 && n < 64) begin step(); n++; end
    chk("defer_wait", n, 22);
    chk("defer_frame", o_frame[0], 2);
    chk("defer_busy", o_busy[0], 1);

    // out-of-range read on the 6x3 instance
    wait_idle_a("idle_wait1");
    rd_x = 3'd7; rd_y = 2'd3;
    step();
    chk("oor_read", o_rd[1], 0);

    // no-clear instance keeps a stale frame in the back bank across swaps
    wr_en = 1'b1; wr_x = 3'd1; wr_y = 2'd1; wr_data = 3'd7;
    step();
    wr_en = 1'b0;
    repeat (3) begin vsync = 1'b1; step(); vsync = 1'b0; step(); end
    rd_x = 3'd1; rd_y = 2'd1;
    step();
    chk("stale_keep", o_rd[1], 7);
    chk("noclr_busy", o_busy[1], 0);

    for (int i = 0; i < 800; i++) begin
      vsync   = ($urandom_range(0, 29) == 0) ? 1'b1 : (vsync & ($urandom_range(0, 1) == 1));
      wr_en   = $urandom_range(0, 1) == 1;
      wr_x    = 3'($urandom_range(0, 7));
      wr_y    = 2'($urandom_range(0, 3));
      wr_data = 3'($urandom_range(0, 7));
      rd_x    = 3'($urandom_range(0, 7));
      rd_y    = 2'($urandom_range(0, 3));
      step();
    end
    vsync = 1'b0; wr_en = 1'b0;
    step();

    // reset in the middle of a clear
    wait_idle_a("idle_wait2");
    vsync = 1'b1; step(); vsync = 1'b0;
    repeat (15) step();
    rst_n = 1'b0;
    model_reset();
    #1 check_all();
    chk("midrst_front", o_front[0], 0);
    chk("midrst_frame", o_frame[0], 0);
    chk("midrst_ready", o_wr_ready[0], 0);
    repeat (2) step();
    rst_n = 1'b1;
    busy_len_a("midrst_clear_len");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
